// File: rtl/sram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sram_arbiter_pkg
// Shared definitions for the SRAM port arbiter and neighbouring memory-bus
// blocks: FSM state encoding, read/write direction encoding and the data
// word returned to a master when its transaction is aborted by the watchdog.
// No ports (package).
// ---------------------------------------------------------------------------
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/sram_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin grant. The grant is combinational from the request
// vector and the remembered last winner; the last winner is only updated
// when the parent actually takes the grant.
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-low reset (last winner -> master 1,
//                 so master 0 wins the first contention)
//   req      in   {m1_valid, m0_valid}
//   update   in   parent is taking the grant this cycle
//   gnt      out  granted master index (0 or 1), meaningful when any_req
//   any_req  out  at least one request is present
// ---------------------------------------------------------------------------
module rr_arbiter2
    import sram_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic       gnt,
    output logic       any_req
);

    logic last_grant;

    // A lone requester always wins. Under contention the master that did
    // not win last time gets the port, which gives strict alternation when
    // both masters keep requesting.
    always_comb begin
        gnt     = 1'b0;
        any_req = |req;
        case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last_grant;
            default: gnt = 1'b0;
        endcase
    end

    // Remember who won, but only when the grant is really consumed; idle
    // cycles and cycles spent serving a transaction leave it untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
        end else if (update && any_req) begin
            last_grant <= gnt;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
// Shares one SRAM port between instruction fetch (m0) and data load/store
// (m1). A transaction is granted in IDLE, presented to the SRAM in REQ until
// srdy (or until the watchdog gives up), then reported back to the granted
// master with a one-cycle ready pulse in RESP. All outputs are registered.
// Ports:
//   clk, reset              clock; asynchronous active-low reset
//   mN_valid/addr/dtw/rw    master N request, held until mN_ready
//   mN_ready                one-cycle completion pulse
//   mN_dtr                  read data (or ERR_DATA on abort), valid with ready
//   mN_err                  qualifies mN_ready: transaction aborted
//   sval/saddr/sdtw/srw     registered SRAM request
//   srdy/sdtr               SRAM completion and read data
// Parameters:
//   TIMEOUT  REQ cycles without srdy before abort (0 disables the watchdog)
//   CNT_W    watchdog width, 2**CNT_W > TIMEOUT
// ---------------------------------------------------------------------------
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_dtw,
    output logic [31:0] m0_dtr,
    input  logic        m0_rw,
    output logic        m0_err,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_dtw,
    output logic [31:0] m1_dtr,
    input  logic        m1_rw,
    output logic        m1_err,
    output logic        sval,
    input  logic        srdy,
    output logic [31:0] saddr,
    output logic [31:0] sdtw,
    input  logic [31:0] sdtr,
    output logic        srw
);

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WD_MAX  = '1;

    state_t           state;
    state_t           state_next;
    logic             gnt;
    logic             gnt_q;
    logic             any_req;
    logic             take_grant;
    logic             timeout_hit;
    logic [CNT_W-1:0] wdog;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     ({m1_valid, m0_valid}),
        .update  (take_grant),
        .gnt     (gnt),
        .any_req (any_req)
    );

    assign take_grant  = (state == ST_IDLE) && any_req;

    // The watchdog compares against its value before this cycle's increment,
    // so sval stays up for exactly TIMEOUT cycles. A srdy arriving in that
    // last cycle still completes normally.
    assign timeout_hit = (state == ST_REQ) && !srdy && (TIMEOUT != 0) && (wdog == WD_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE waits for any request, REQ waits for srdy or
    // the watchdog, RESP always lasts a single cycle so there is one IDLE
    // bubble between consecutive transactions.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (any_req) state_next = ST_REQ;
            ST_REQ:  if (srdy || timeout_hit) state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs. The request is latched once at grant
    // time, so later changes on the master's addr/dtw/rw are ignored. The
    // ready/err pulses are set on the way into RESP and cleared by default
    // every other cycle. Read data only overwrites dtr on reads; writes keep
    // the previous value. srdy outside REQ is never looked at.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sval     <= 1'b0;
            saddr    <= '0;
            sdtw     <= '0;
            srw      <= RW_READ;
            gnt_q    <= 1'b0;
            wdog     <= '0;
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
            m0_err   <= 1'b0;
            m1_err   <= 1'b0;
            m0_dtr   <= '0;
            m1_dtr   <= '0;
        end else begin
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
            m0_err   <= 1'b0;
            m1_err   <= 1'b0;

            if (take_grant) begin
                sval  <= 1'b1;
                saddr <= gnt ? m1_addr : m0_addr;
                sdtw  <= gnt ? m1_dtw  : m0_dtw;
                srw   <= gnt ? m1_rw   : m0_rw;
                gnt_q <= gnt;
                wdog  <= '0;
            end

            if (state == ST_REQ) begin
                if (srdy) begin
                    sval <= 1'b0;
                    if (srw == RW_READ) begin
                        if (gnt_q) m1_dtr <= sdtr;
                        else       m0_dtr <= sdtr;
                    end
                    if (gnt_q) m1_ready <= 1'b1;
                    else       m0_ready <= 1'b1;
                end else if (timeout_hit) begin
                    sval <= 1'b0;
                    if (gnt_q) begin
                        m1_dtr   <= ERR_DATA;
                        m1_ready <= 1'b1;
                        m1_err   <= 1'b1;
                    end else begin
                        m0_dtr   <= ERR_DATA;
                        m0_ready <= 1'b1;
                        m0_err   <= 1'b1;
                    end
                end else if (wdog != WD_MAX) begin
                    wdog <= wdog + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
// Self-checking bench for sram_arbiter (TIMEOUT = 4). Two master processes
// issue random reads/writes, an SRAM responder answers after a chosen delay
// (or never, to provoke the watchdog) and scatters stray srdy pulses while no
// request is pending. The responder predicts each transaction outcome from the
// arbitration and completion rules and queues it; a monitor pops the queue on
// every ready pulse and compares.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    localparam int TIMEOUT = 4;
    localparam int NTX     = 40;
    localparam int NBURST  = 12;

    typedef struct {
        int          g;
        logic        err;
        logic [31:0] dtr;
    } resp_t;

    logic        clk;
    logic        reset;
    logic        m0_valid, m0_ready, m0_rw, m0_err;
    logic [31:0] m0_addr, m0_dtw, m0_dtr;
    logic        m1_valid, m1_ready, m1_rw, m1_err;
    logic [31:0] m1_addr, m1_dtw, m1_dtr;
    logic        sval, srdy, srw;
    logic [31:0] saddr, sdtw, sdtr;

    int          tests = 0;
    int          fails = 0;
    int          cycle = 0;
    int          last_ready = -1;
    int          txn_count = 0;
    int          last_grant_model = 1;
    bit          run_sram = 0;
    bit          run_mon = 0;
    bit          burst = 0;
    bit          granted [2];
    logic [31:0] req_addr [2];
    logic [31:0] req_dtw [2];
    logic        req_rw [2];
    logic [31:0] model_dtr [2];
    resp_t       exp_q [$];

    sram_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_valid (m0_valid),
        .m0_ready (m0_ready),
        .m0_addr  (m0_addr),
        .m0_dtw   (m0_dtw),
        .m0_dtr   (m0_dtr),
        .m0_rw    (m0_rw),
        .m0_err   (m0_err),
        .m1_valid (m1_valid),
        .m1_ready (m1_ready),
        .m1_addr  (m1_addr),
        .m1_dtw   (m1_dtw),
        .m1_dtr   (m1_dtr),
        .m1_rw    (m1_rw),
        .m1_err   (m1_err),
        .sval     (sval),
        .srdy     (srdy),
        .saddr    (saddr),
        .sdtw     (sdtw),
        .sdtr     (sdtr),
        .srw      (srw)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic reportFail(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: event not as required (cycle %0d)", name, cycle);
    endtask

    function automatic logic readyOf(input int g);
        return (g == 1) ? m1_ready : m0_ready;
    endfunction

    task automatic driveMaster(input int g, input logic v, input logic [31:0] a,
                               input logic [31:0] d, input logic rw);
        if (g == 0) begin
            m0_valid = v; m0_addr = a; m0_dtw = d; m0_rw = rw;
        end else begin
            m1_valid = v; m1_addr = a; m1_dtw = d; m1_rw = rw;
        end
    endtask

    // One master: n transactions. Called at posedge+1. After its request has
    // been granted the master may scramble addr/dtw/rw and, outside
    // contention bursts, drop valid early; neither may disturb the transaction.
    task automatic applyStimulus(input int g, input int n, input bit contend);
        int          gap;
        int          waited;
        bit          seen;
        bit          dropped;
        logic [31:0] a;
        logic [31:0] d;
        logic        rw;
        for (int t = 0; t < n; t++) begin
            gap = contend ? 0 : int'($urandom_range(0, 3));
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            a  = $urandom & 32'hFFFF_FFFC;
            d  = $urandom;
            rw = 1'($urandom_range(0, 1));
            req_addr[g] = a;
            req_dtw[g]  = d;
            req_rw[g]   = rw;
            granted[g]  = 1'b0;
            driveMaster(g, 1'b1, a, d, rw);
            seen    = 1'b0;
            dropped = 1'b0;
            waited  = 0;
            while (!seen && waited < 200) begin
                @(posedge clk);
                #1;
                waited++;
                if (readyOf(g)) begin
                    seen = 1'b1;
                end else if (granted[g] && $urandom_range(0, 2) == 0) begin
                    if (!contend && $urandom_range(0, 1) == 0) dropped = 1'b1;
                    driveMaster(g, !dropped, $urandom, $urandom, 1'($urandom_range(0, 1)));
                end
            end
            if (!seen) reportFail($sformatf("m%0d_ready_timeout", g));
            driveMaster(g, 1'b0, '0, '0, RW_READ);
        end
    endtask

    // Handles one SRAM transaction, entered at the negedge of its first REQ
    // cycle. pv holds the valids the arbiter saw in the preceding IDLE cycle.
    // srdy is raised in REQ cycle d (0-based); with no srdy by cycle
    // TIMEOUT-1 the transaction must abort.
    task automatic serveRequest(input logic [1:0] pv);
        int          g;
        int          d;
        bit          done_tx;
        logic [31:0] ea;
        logic [31:0] ed;
        logic        erw;
        logic [31:0] rdata;
        resp_t       r;
        g = 0;
        case (pv)
            2'b01:   g = 0;
            2'b10:   g = 1;
            2'b11:   g = 1 - last_grant_model;
            default: reportFail("grant_without_request");
        endcase
        last_grant_model = g;
        ea  = req_addr[g];
        ed  = req_dtw[g];
        erw = req_rw[g];
        granted[g] = 1'b1;
        if (burst)             d = 0;
        else if (txn_count < 6) d = txn_count;
        else                   d = int'($urandom_range(0, TIMEOUT + 1));
        txn_count++;
        done_tx = 1'b0;
        for (int i = 0; !done_tx; i++) begin
            if (i > 0) @(negedge clk);
            checkBit("sval_in_req", sval, 1'b1);
            checkOutput("saddr", saddr, ea);
            checkOutput("sdtw", sdtw, ed);
            checkBit("srw", srw, erw);
            if (i == d) begin
                rdata = $urandom;
                srdy  = 1'b1;
                sdtr  = rdata;
                if (erw == RW_READ) model_dtr[g] = rdata;
                r.g = g; r.err = 1'b0; r.dtr = model_dtr[g];
                exp_q.push_back(r);
                done_tx = 1'b1;
            end else begin
                srdy = 1'b0;
                sdtr = $urandom;
                if (i == TIMEOUT - 1) begin
                    model_dtr[g] = ERR_DATA;
                    r.g = g; r.err = 1'b1; r.dtr = ERR_DATA;
                    exp_q.push_back(r);
                    done_tx = 1'b1;
                end
            end
        end
        @(negedge clk);
        checkBit("sval_after_end", sval, 1'b0);
        checkBit("ready_latency", readyOf(g), 1'b1);
        srdy = ($urandom_range(0, 2) == 0);
        sdtr = $urandom;
    endtask

    // SRAM responder: serves requests, sprinkles stray srdy otherwise.
    initial begin
        logic [1:0] prev_valid;
        prev_valid = 2'b00;
        srdy = 1'b0;
        sdtr = '0;
        forever begin
            @(negedge clk);
            if (run_sram && sval) begin
                serveRequest(prev_valid);
            end else if (run_sram) begin
                srdy = ($urandom_range(0, 2) == 0);
                sdtr = $urandom;
            end else begin
                srdy = 1'b0;
            end
            prev_valid = {m1_valid, m0_valid};
        end
    end

    // Monitor: every ready pulse must match the oldest queued prediction.
    initial begin
        resp_t r;
        int    g;
        forever begin
            @(negedge clk);
            if (run_mon) begin
                if (m0_ready && m1_ready) begin
                    reportFail("both_ready");
                end else if (m0_ready || m1_ready) begin
                    g = m1_ready ? 1 : 0;
                    if (exp_q.size() == 0) begin
                        reportFail("unexpected_ready");
                    end else begin
                        r = exp_q.pop_front();
                        checkOutput("ready_master", 32'(g), 32'(r.g));
                        checkBit("err", (g == 1) ? m1_err : m0_err, r.err);
                        checkOutput("dtr", (g == 1) ? m1_dtr : m0_dtr, r.dtr);
                        checkBit("other_err", (g == 1) ? m0_err : m1_err, 1'b0);
                        checkOutput("other_dtr", (g == 1) ? m0_dtr : m1_dtr, model_dtr[1 - g]);
                    end
                    if (burst && last_ready >= 0) checkOutput("burst_spacing", 32'(cycle - last_ready), 32'd3);
                    last_ready = cycle;
                end else if (m0_err || m1_err) begin
                    reportFail("err_without_ready");
                end
            end
        end
    end

    initial begin
        #400000;
        reportFail("global_timeout");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Wait until every predicted response has been seen and the port is idle.
    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || sval) && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 100) reportFail("drain_timeout");
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Main sequence: reset values, async reset during REQ, random traffic,
    // then a contention burst with srdy answered immediately.
    initial begin
        int w;
        reset = 1'b0;
        driveMaster(0, 1'b0, '0, '0, RW_READ);
        driveMaster(1, 1'b0, '0, '0, RW_READ);
        model_dtr[0] = '0;
        model_dtr[1] = '0;
        granted[0]   = 1'b0;
        granted[1]   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkBit("rst_sval", sval, 1'b0);
        checkOutput("rst_saddr", saddr, 32'h0);
        checkOutput("rst_sdtw", sdtw, 32'h0);
        checkBit("rst_srw", srw, 1'b0);
        checkBit("rst_m0_ready", m0_ready, 1'b0);
        checkBit("rst_m1_ready", m1_ready, 1'b0);
        checkBit("rst_m0_err", m0_err, 1'b0);
        checkBit("rst_m1_err", m1_err, 1'b0);
        checkOutput("rst_m0_dtr", m0_dtr, 32'h0);
        checkOutput("rst_m1_dtr", m1_dtr, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        driveMaster(0, 1'b1, 32'h0000_0100, 32'h0, RW_READ);
        w = 0;
        while (!sval && w < 10) begin
            @(posedge clk);
            #1;
            w++;
        end
        checkBit("dir_sval_up", sval, 1'b1);
        checkOutput("dir_saddr", saddr, 32'h0000_0100);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkBit("async_rst_sval", sval, 1'b0);
        checkOutput("async_rst_saddr", saddr, 32'h0);
        checkBit("async_rst_m0_ready", m0_ready, 1'b0);
        driveMaster(0, 1'b0, '0, '0, RW_READ);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkBit("idle_after_rst", sval, 1'b0);
        checkBit("no_ready_after_rst", m0_ready, 1'b0);
        last_grant_model = 1;
        txn_count = 0;

        run_sram = 1'b1;
        run_mon  = 1'b1;
        fork
            applyStimulus(0, NTX, 1'b0);
            applyStimulus(1, NTX, 1'b0);
        join
        drain();

        burst = 1'b1;
        last_ready = -1;
        fork
            applyStimulus(0, NBURST, 1'b1);
            applyStimulus(1, NBURST, 1'b1);
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
